cordic_vectoring: RTL

Iterative CORDIC engine running in vectoring mode: accepts a signed I/Q sample and drives Y to zero, accumulating the rotation angle. It produces the magnitude (CORDIC gain uncompensated) and the phase of the vector. It performs the inverse conversion of the rotation-mode CORDIC used in the DDC/DUC mixers. The block sits behind the receive chain for AM/FM demodulation and RSSI/phase readback. It computes one micro-rotation per clock and exchanges data over valid/ready handshakes.

---
 rtl/cordic_pkg.sv | 48 ++++
 rtl/cordic_microrot.sv | 46 ++++
 rtl/cordic_vectoring.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/cordic_pkg.sv
// -----------------------------------------------------------------------------
// cordic_pkg
// Shared constants for the vectoring CORDIC engine:
//   - FSM state encoding (IDLE / ROT / DONE)
//   - arctangent table atan(2^-i) in 32-bit binary angle measure
//     (2^32 = 360 degrees), plus a helper that rounds it to a narrower
//     phase width
//   - CORDIC gain constant in Q16 for consumers that want to compensate
//     the magnitude output
// -----------------------------------------------------------------------------
package cordic_pkg;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_ROT  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   // Product of sqrt(1 + 2^-2i) over the iterations, ~1.64676, in Q16.
   localparam int unsigned CORDIC_GAIN_Q16 = 107922;

   localparam int ATAN_N = 24;

   // round(atan(2^-i) * 2^32 / (2*pi))
   localparam logic [31:0] ATAN32 [ATAN_N] = '{
      32'h20000000, 32'h12E4051E, 32'h09FB385B, 32'h051111D4,
      32'h028B0D43, 32'h0145D7E1, 32'h00A2F61E, 32'h00517C55,
      32'h0028BE53, 32'h00145F2F, 32'h000A2F98, 32'h000517CC,
      32'h00028BE6, 32'h000145F3, 32'h0000A2FA, 32'h0000517D,
      32'h000028BE, 32'h0000145F, 32'h00000A30, 32'h00000518,
      32'h0000028C, 32'h00000146, 32'h000000A3, 32'h00000051
   };

   // Table entry idx reduced to zw bits with round-half-up; result sits in
   // the low zw bits. Indices past the table return 0 (angle below 1 LSB).
   function automatic logic [31:0] atan_lookup(input int idx, input int zw);
      logic [63:0] full;
      logic [63:0] rnd;
      if (idx < 0 || idx >= ATAN_N) begin
         return 32'd0;
      end
      full = {32'd0, ATAN32[idx]};
      if (zw >= 32) begin
         return ATAN32[idx];
      end
      rnd = (full + (64'd1 << (31 - zw))) >> (32 - zw);
      return rnd[31:0];
   endfunction

endpackage

// File: rtl/cordic_microrot.sv
// -----------------------------------------------------------------------------
// cordic_microrot
// One combinational vectoring-mode micro-rotation. The sign of y selects the
// rotation direction so that y is driven towards zero; z accumulates the
// applied angle modulo 2^ZW.
// Ports:
//   x_in, y_in  signed W-bit current vector
//   z_in        ZW-bit accumulated angle
//   shift       iteration index i (shift amount)
//   atan        atan(2^-i) in ZW-bit binary angle measure
//   x_out, y_out, z_out  rotated vector and updated angle
// -----------------------------------------------------------------------------
module cordic_microrot #(
   parameter int W  = 18,
   parameter int ZW = 16,
   parameter int SW = 5
) (
   input  logic signed [W-1:0]  x_in,
   input  logic signed [W-1:0]  y_in,
   input  logic        [ZW-1:0] z_in,
   input  logic        [SW-1:0] shift,
   input  logic        [ZW-1:0] atan,
   output logic signed [W-1:0]  x_out,
   output logic signed [W-1:0]  y_out,
   output logic        [ZW-1:0] z_out
);

   logic signed [W-1:0] x_sh;
   logic signed [W-1:0] y_sh;

   always_comb begin
      x_sh = x_in >>> shift;
      y_sh = y_in >>> shift;
      // Both updates use the old x/y values.
      if (!y_in[W-1]) begin
         x_out = x_in + y_sh;
         y_out = y_in - x_sh;
         z_out = z_in + atan;
      end else begin
         x_out = x_in - y_sh;
         y_out = y_in + x_sh;
         z_out = z_in - atan;
      end
   end

endmodule

// File: rtl/cordic_vectoring.sv
// -----------------------------------------------------------------------------
// cordic_vectoring
// Iterative vectoring-mode CORDIC: one micro-rotation per clock. Converts a
// signed I/Q sample into an uncompensated magnitude (~1.6468*|v|) and a phase
// in binary angle measure (2^zwidth = 360 degrees).
// Ports:
//   clock      rising-edge clock
//   reset      asynchronous, active-low
//   in_valid / in_ready / xi / yi       input handshake and sample
//   out_valid / out_ready / mag / phase output handshake and result
// -----------------------------------------------------------------------------
module cordic_vectoring
   import cordic_pkg::*;
#(
   parameter int bitwidth = 16,
   parameter int zwidth   = 16,
   parameter int stages   = 14
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic signed [bitwidth-1:0] xi,
   input  logic signed [bitwidth-1:0] yi,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic        [bitwidth:0]   mag,
   output logic        [zwidth-1:0]   phase
);

   // Two guard bits: one for negating -2^(bitwidth-1), one for CORDIC growth.
   localparam int W  = bitwidth + 2;
   localparam int IW = $clog2(bitwidth + 1);
   localparam logic [IW-1:0]     I_LAST = IW'(stages - 1);
   localparam logic [zwidth-1:0] Z_HALF = {1'b1, {(zwidth - 1){1'b0}}};

   logic [1:0]              state_q, state_d;
   logic [IW-1:0]           i_q, i_d;
   logic signed [W-1:0]     x_q, x_d, y_q, y_d;
   logic [zwidth-1:0]       z_q, z_d;
   logic                    zero_q, zero_d;
   logic [bitwidth:0]       mag_q, mag_d;
   logic [zwidth-1:0]       phase_q, phase_d;

   logic signed [W-1:0]     xi_ext, yi_ext;
   logic signed [W-1:0]     x_n, y_n;
   logic [zwidth-1:0]       z_n;
   logic [zwidth-1:0]       atan_c;
   logic                    accept;

   assign in_ready  = (state_q == ST_IDLE) && reset;
   assign out_valid = (state_q == ST_DONE);
   assign mag       = mag_q;
   assign phase     = phase_q;
   assign accept    = in_valid && in_ready;

   assign xi_ext = {{2{xi[bitwidth-1]}}, xi};
   assign yi_ext = {{2{yi[bitwidth-1]}}, yi};
   assign atan_c = zwidth'(atan_lookup(int'(i_q), zwidth));

   cordic_microrot #(
      .W  (W),
      .ZW (zwidth),
      .SW (IW)
   ) u_microrot (
      .x_in  (x_q),
      .y_in  (y_q),
      .z_in  (z_q),
      .shift (i_q),
      .atan  (atan_c),
      .x_out (x_n),
      .y_out (y_n),
      .z_out (z_n)
   );

   always_comb begin
      state_d = state_q;
      i_d     = i_q;
      x_d     = x_q;
      y_d     = y_q;
      z_d     = z_q;
      zero_d  = zero_q;
      mag_d   = mag_q;
      phase_d = phase_q;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               state_d = ST_ROT;
               i_d     = '0;
               zero_d  = (xi == '0) && (yi == '0);
               // Left half-plane: rotate by 180 degrees so the iterations
               // only need to cover +/-90 degrees.
               if (xi[bitwidth-1]) begin
                  x_d = -xi_ext;
                  y_d = -yi_ext;
                  z_d = Z_HALF;
               end else begin
                  x_d = xi_ext;
                  y_d = yi_ext;
                  z_d = '0;
               end
            end
         end
         ST_ROT: begin
            x_d = x_n;
            y_d = y_n;
            z_d = z_n;
            if (i_q == I_LAST) begin
               state_d = ST_DONE;
               i_d     = '0;
               mag_d   = x_n[bitwidth:0];
               // The iteration drifts off zero for a null vector; force 0.
               phase_d = zero_q ? '0 : z_n;
            end else begin
               i_d = i_q + 1'b1;
            end
         end
         ST_DONE: begin
            if (out_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         i_q     <= '0;
         mag_q   <= '0;
         phase_q <= '0;
      end else begin
         state_q <= state_d;
         i_q     <= i_d;
         mag_q   <= mag_d;
         phase_q <= phase_d;
      end
   end

   // Working registers are only meaningful in ROT; no reset needed.
   always_ff @(posedge clock) begin
      x_q    <= x_d;
      y_q    <= y_d;
      z_q    <= z_d;
      zero_q <= zero_d;
   end

endmodule
